// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with a frame format fixed at elaboration.
// The frame has 5..9 data bits sent LSB first, optional odd or even parity, and 1 or 2 stop bits.
// It contains a line synchroniser, false-start rejection, parity and framing error flags,
// and a valid/ready holding register that flags an overrun.
//
// Ports:
//   uart_clock       in   system clock, rising edge
//   uart_reset       in   asynchronous active-high reset
//   uart_d_in        in   serial line (asynchronous, idles high)
//   uart_ready       in   consumer accepts the held word while uart_valid is high
//   uart_d_out       out  received word [DATA_BITS-1:0]
//   uart_valid       out  uart_d_out and the error flags hold a word
//   uart_parity_err  out  parity mismatch for the held word
//   uart_frame_err   out  a stop bit of the held word was sampled low
//   uart_overrun     out  one-cycle pulse: a completed frame was dropped
module uart_rx_cfg #(
   parameter int unsigned CLOCK_FREQ = 100000000,
   parameter int unsigned BAUD_RATE  = 4000000,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 uart_clock,
   input  logic                 uart_reset,
   input  logic                 uart_d_in,
   input  logic                 uart_ready,
   output logic [DATA_BITS-1:0] uart_d_out,
   output logic                 uart_valid,
   output logic                 uart_parity_err,
   output logic                 uart_frame_err,
   output logic                 uart_overrun
);

   localparam int unsigned BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CW        = $clog2(BIT_TICKS);
   localparam int unsigned HALF      = BIT_TICKS / 2;
   localparam int unsigned BCW       = 4;
   localparam bit          PAR_ODD   = (PARITY == 32'd1);
   localparam bit          PAR_EN    = (PARITY != 32'd0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               r_state, w_state_next;
   logic                 r_sync1, r_sync2, r_rxs_q;
   logic [CW-1:0]        r_cnt, w_cnt_next;
   logic [BCW-1:0]       r_bit, w_bit_next;
   logic [DATA_BITS-1:0] r_shift, w_shift_next;
   logic                 r_par_err, w_par_next;
   logic                 r_frm_err, w_frm_next;
   logic                 w_done;
   logic                 w_rxs;
   logic                 w_tick;

   assign w_rxs  = r_sync2;
   assign w_tick = (r_cnt == CW'(BIT_TICKS - 1));

   // Line synchroniser plus one delay flop for falling-edge detection
   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rxs_q <= 1'b1;
      end else begin
         r_sync1 <= uart_d_in;
         r_sync2 <= r_sync1;
         r_rxs_q <= r_sync2;
      end
   end

   // State and frame datapath registers
   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit     <= w_bit_next;
         r_shift   <= w_shift_next;
         r_par_err <= w_par_next;
         r_frm_err <= w_frm_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_par_next   = r_par_err;
      w_frm_next   = r_frm_err;
      w_done       = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            w_bit_next = '0;
            // rxs_q must be high, so a line stuck low after a bad stop bit cannot restart
            if (r_rxs_q && !w_rxs) begin
               w_state_next = S_START;
               w_par_next   = 1'b0;
               w_frm_next   = 1'b0;
            end
         end
         S_START: begin
            if (r_cnt == CW'(HALF - 1)) begin
               w_cnt_next   = '0;
               // High at mid start bit means a glitch: drop it silently
               w_state_next = w_rxs ? S_IDLE : S_DATA;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_cnt_next   = '0;
               w_shift_next = {w_rxs, r_shift[DATA_BITS-1:1]};
               if (r_bit == BCW'(DATA_BITS - 1)) begin
                  w_bit_next   = '0;
                  w_state_next = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  w_bit_next = r_bit + BCW'(1);
               end
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               w_cnt_next   = '0;
               w_par_next   = ((^r_shift) ^ w_rxs) != PAR_ODD;
               w_state_next = S_STOP;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (w_tick) begin
               w_cnt_next = '0;
               w_frm_next = r_frm_err | ~w_rxs;
               if (r_bit == BCW'(STOP_BITS - 1)) begin
                  w_bit_next   = '0;
                  w_done       = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_bit_next = r_bit + BCW'(1);
               end
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_bit_next   = '0;
         end
      endcase
   end

   // Output holding register: a completing frame loads the register if it is free or being accepted
   always_ff @(posedge uart_clock or posedge uart_reset) begin
      if (uart_reset) begin
         uart_d_out      <= '0;
         uart_valid      <= 1'b0;
         uart_parity_err <= 1'b0;
         uart_frame_err  <= 1'b0;
         uart_overrun    <= 1'b0;
      end else begin
         uart_overrun <= 1'b0;
         if (w_done) begin
            if (!uart_valid || uart_ready) begin
               uart_d_out      <= r_shift;
               uart_parity_err <= r_par_err;
               uart_frame_err  <= w_frm_next;
               uart_valid      <= 1'b1;
            end else begin
               uart_overrun <= 1'b1;
            end
         end else if (uart_valid && uart_ready) begin
            uart_valid <= 1'b0;
         end
      end
   end

endmodule
